// File: rtl/raster_engine.sv
// raster_engine: walks the pixels covered by one raster command (fill, point,
// line, filled rect) and emits framebuffer writes under fb_ready backpressure.
// Optional accepted-write counter: define RASTER_PERF_COUNT_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for gpu_execute_request, outputs quiet
// S_FILL  | row-major sweep of the whole framebuffer
// S_POINT | single pixel at (x0,y0)
// S_RECT  | row-major sweep of the inclusive min/max box
// S_LINE  | Bresenham walk from (x0,y0) to (x1,y1)

package raster_pkg;
   typedef enum logic [1:0] {
      CMD_FILL  = 2'd0,
      CMD_POINT = 2'd1,
      CMD_LINE  = 2'd2,
      CMD_RECT  = 2'd3
   } raster_command_t;
endpackage

module raster_engine #(
   parameter int FB_WIDTH  = 213,
   parameter int FB_HEIGHT = 160,
   parameter int ADDR_W    = 16
) (
   input  logic                        clk,
   input  logic                        rst_async,
   input  raster_pkg::raster_command_t gpu_command,
   input  logic [7:0]                  gpu_x0,
   input  logic [7:0]                  gpu_y0,
   input  logic [7:0]                  gpu_x1,
   input  logic [7:0]                  gpu_y1,
   input  logic [2:0]                  gpu_colour,
   input  logic                        gpu_execute_request,
   output logic                        gpu_busy,
   output logic                        fb_we,
   output logic [ADDR_W-1:0]           fb_addr,
   output logic [2:0]                  fb_data,
   input  logic                        fb_ready,
   output logic [31:0]                 perf_pixels
);
   import raster_pkg::*;

   typedef enum logic [2:0] {S_IDLE, S_FILL, S_POINT, S_RECT, S_LINE} state_e;

   localparam logic [8:0]        FB_W9   = 9'(FB_WIDTH);
   localparam logic [8:0]        FB_H9   = 9'(FB_HEIGHT);
   localparam logic [7:0]        FB_XMAX = 8'(FB_WIDTH - 1);
   localparam logic [7:0]        FB_YMAX = 8'(FB_HEIGHT - 1);
   localparam logic [ADDR_W-1:0] FB_W_A  = ADDR_W'(FB_WIDTH);

   state_e             state_q, state_d;
   logic [7:0]         x_q, x_d, y_q, y_d;
   logic [7:0]         xl_q, xl_d;              // rect left edge for row wrap
   logic [7:0]         end_x_q, end_x_d;        // rect xh / line x1
   logic [7:0]         end_y_q, end_y_d;        // rect yh / line y1
   logic [2:0]         colour_q, colour_d;
   logic signed [8:0]  dx_q, dx_d;              // |dx|
   logic signed [8:0]  dy_q, dy_d;              // -|dy|
   logic               sx_q, sx_d, sy_q, sy_d;  // 1 = step negative
   logic signed [9:0]  err_q, err_d;

   logic               onscreen, adv;
   logic signed [8:0]  ddx, ddy, adx, ady;
   logic signed [10:0] e2, dx11, dy11;
   logic signed [9:0]  err_x, err_y;
   logic [7:0]         lo_x, hi_x, lo_y, hi_y;

   // Next-state, pixel stepping and output decode.
   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      xl_d     = xl_q;
      end_x_d  = end_x_q;
      end_y_d  = end_y_q;
      colour_d = colour_q;
      dx_d     = dx_q;
      dy_d     = dy_q;
      sx_d     = sx_q;
      sy_d     = sy_q;
      err_d    = err_q;

      gpu_busy = (state_q != S_IDLE);
      onscreen = ({1'b0, x_q} < FB_W9) && ({1'b0, y_q} < FB_H9);
      fb_we    = gpu_busy && onscreen;
      fb_addr  = gpu_busy ? (ADDR_W'(y_q) * FB_W_A + ADDR_W'(x_q)) : '0;
      fb_data  = gpu_busy ? colour_q : 3'd0;
      // clipped pixels advance without waiting for the framebuffer
      adv      = gpu_busy && (!onscreen || fb_ready);

      ddx   = 9'({1'b0, gpu_x1} - {1'b0, gpu_x0});
      ddy   = 9'({1'b0, gpu_y1} - {1'b0, gpu_y0});
      adx   = ddx[8] ? -ddx : ddx;
      ady   = ddy[8] ? -ddy : ddy;
      lo_x  = (gpu_x0 < gpu_x1) ? gpu_x0 : gpu_x1;
      hi_x  = (gpu_x0 < gpu_x1) ? gpu_x1 : gpu_x0;
      lo_y  = (gpu_y0 < gpu_y1) ? gpu_y0 : gpu_y1;
      hi_y  = (gpu_y0 < gpu_y1) ? gpu_y1 : gpu_y0;

      e2    = {err_q, 1'b0};
      dx11  = {{2{dx_q[8]}}, dx_q};
      dy11  = {{2{dy_q[8]}}, dy_q};
      err_x = (e2 >= dy11) ? {dy_q[8], dy_q} : 10'sd0;
      err_y = (e2 <= dx11) ? {dx_q[8], dx_q} : 10'sd0;

      case (state_q)
         S_IDLE: begin
            if (gpu_execute_request) begin
               colour_d = gpu_colour;
               x_d      = gpu_x0;
               y_d      = gpu_y0;
               end_x_d  = gpu_x1;
               end_y_d  = gpu_y1;
               case (gpu_command)
                  CMD_FILL: begin
                     x_d     = 8'd0;
                     y_d     = 8'd0;
                     state_d = S_FILL;
                  end
                  CMD_POINT: state_d = S_POINT;
                  CMD_RECT: begin
                     x_d     = lo_x;
                     y_d     = lo_y;
                     xl_d    = lo_x;
                     end_x_d = hi_x;
                     end_y_d = hi_y;
                     state_d = S_RECT;
                  end
                  default: begin
                     sx_d    = ddx[8];
                     sy_d    = ddy[8];
                     dx_d    = adx;
                     dy_d    = -ady;
                     err_d   = 10'({adx[8], adx} + {dy_d[8], dy_d});
                     state_d = S_LINE;
                  end
               endcase
            end
         end
         S_FILL: begin
            if (adv) begin
               if (x_q == FB_XMAX) begin
                  x_d = 8'd0;
                  if (y_q == FB_YMAX) state_d = S_IDLE;
                  else                y_d = y_q + 8'd1;
               end else begin
                  x_d = x_q + 8'd1;
               end
            end
         end
         S_POINT: begin
            if (adv) state_d = S_IDLE;
         end
         S_RECT: begin
            if (adv) begin
               if (x_q == end_x_q) begin
                  if (y_q == end_y_q) state_d = S_IDLE;
                  else begin
                     x_d = xl_q;
                     y_d = y_q + 8'd1;
                  end
               end else begin
                  x_d = x_q + 8'd1;
               end
            end
         end
         S_LINE: begin
            if (adv) begin
               if (x_q == end_x_q && y_q == end_y_q) begin
                  state_d = S_IDLE;
               end else begin
                  err_d = err_q + err_x + err_y;
                  if (e2 >= dy11) x_d = sx_q ? x_q - 8'd1 : x_q + 8'd1;
                  if (e2 <= dx11) y_d = sy_q ? y_q - 8'd1 : y_q + 8'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Command and walker registers.
   always_ff @(posedge clk or negedge rst_async) begin
      if (!rst_async) begin
         state_q  <= S_IDLE;
         x_q      <= '0;
         y_q      <= '0;
         xl_q     <= '0;
         end_x_q  <= '0;
         end_y_q  <= '0;
         colour_q <= '0;
         dx_q     <= '0;
         dy_q     <= '0;
         sx_q     <= 1'b0;
         sy_q     <= 1'b0;
         err_q    <= '0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         xl_q     <= xl_d;
         end_x_q  <= end_x_d;
         end_y_q  <= end_y_d;
         colour_q <= colour_d;
         dx_q     <= dx_d;
         dy_q     <= dy_d;
         sx_q     <= sx_d;
         sy_q     <= sy_d;
         err_q    <= err_d;
      end
   end

`ifdef RASTER_PERF_COUNT_EN
   logic [31:0] perf_q, perf_d;

   // Count accepted writes; wraps naturally, cleared only by reset.
   always_comb begin
      perf_d = perf_q + {31'd0, (fb_we && fb_ready)};
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_async) begin
      if (!rst_async) perf_q <= '0;
      else            perf_q <= perf_d;
   end

   assign perf_pixels = perf_q;
`else
   assign perf_pixels = 32'd0;
`endif

endmodule

// File: tb/tb_raster_engine.sv
// Scoreboard bench for raster_engine: stimulus pushes expected writes
// (addr<<3 | colour), a negedge monitor pops and compares each accepted write.
module tb_raster_engine;
   import raster_pkg::*;

   logic            clk = 1'b0;
   logic            rst_async = 1'b0;
   raster_command_t gpu_command = CMD_FILL;
   logic [7:0]      gpu_x0 = '0, gpu_y0 = '0, gpu_x1 = '0, gpu_y1 = '0;
   logic [2:0]      gpu_colour = '0;
   logic            gpu_execute_request = 1'b0;
   logic            gpu_busy, fb_we;
   logic [15:0]     fb_addr;
   logic [2:0]      fb_data;
   logic            fb_ready = 1'b1;
   logic [31:0]     perf_pixels;

   int checks = 0;
   int errors = 0;
   int exp_q[$];
   bit toggle_en = 1'b0;
   bit mon_free  = 1'b0;
   int last_addr = -1;

   raster_engine dut (
      .clk(clk), .rst_async(rst_async), .gpu_command(gpu_command),
      .gpu_x0(gpu_x0), .gpu_y0(gpu_y0), .gpu_x1(gpu_x1), .gpu_y1(gpu_y1),
      .gpu_colour(gpu_colour), .gpu_execute_request(gpu_execute_request),
      .gpu_busy(gpu_busy), .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
      .fb_ready(fb_ready), .perf_pixels(perf_pixels)
   );

   always #10 clk = ~clk;

   function automatic void chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endfunction

   function automatic void push_px(int x, int y, int col);
      exp_q.push_back(((y * 213 + x) << 3) | col);
   endfunction

   // fb_ready driver: constant 1, or alternating when toggle_en
   initial forever begin
      @(posedge clk);
      #1;
      fb_ready = toggle_en ? ~fb_ready : 1'b1;
   end

   // Monitor: compare every accepted write, and hold-stability under stall
   initial begin
      bit         hold = 1'b0;
      logic [15:0] h_addr;
      logic [2:0]  h_data;
      int          e;
      forever begin
         @(negedge clk);
         if (hold && !mon_free) begin
            chk("stall_addr_stable", fb_addr, h_addr);
            chk("stall_data_stable", fb_data, h_data);
         end
         hold = 1'b0;
         if (fb_we && !fb_ready) begin
            hold   = 1'b1;
            h_addr = fb_addr;
            h_data = fb_data;
         end
         if (fb_we && fb_ready && !mon_free) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_write_addr", fb_addr, -1);
            end else begin
               e = exp_q.pop_front();
               chk("write_addr", fb_addr, e >> 3);
               chk("write_data", fb_data, e & 7);
               last_addr = fb_addr;
            end
         end
      end
   end

   task automatic start_cmd(raster_command_t c, int x0, int y0, int x1, int y1, int col);
      @(posedge clk);
      #1;
      gpu_command = c;
      gpu_x0 = 8'(x0); gpu_y0 = 8'(y0); gpu_x1 = 8'(x1); gpu_y1 = 8'(y1);
      gpu_colour = 3'(col);
      gpu_execute_request = 1'b1;
      @(posedge clk);
      #1;
      gpu_execute_request = 1'b0;
   endtask

   task automatic wait_idle(output int cycles);
      cycles = 0;
      for (int i = 0; i < 80000; i++) begin
         @(negedge clk);
         if (!gpu_busy) return;
         cycles++;
      end
      chk("busy_timeout", cycles, -1);
   endtask

   initial begin
      int bc;
      // reset state
      repeat (3) @(negedge clk);
      chk("rst_busy", gpu_busy, 0);
      chk("rst_we", fb_we, 0);
      chk("rst_addr", fb_addr, 0);
      chk("rst_data", fb_data, 0);
      chk("rst_perf", perf_pixels, 0);
      rst_async = 1'b1;
      repeat (2) @(negedge clk);

      // POINT (10,20) colour 5: write in N+1, idle in N+2
      push_px(10, 20, 5);
      start_cmd(CMD_POINT, 10, 20, 0, 0, 5);
      @(negedge clk);
      chk("point_we", fb_we, 1);
      chk("point_addr", fb_addr, 4270);
      chk("point_data", fb_data, 5);
      @(negedge clk);
      chk("point_busy_drop", gpu_busy, 0);
      chk("point_q_empty", exp_q.size(), 0);

      // RECT with swapped corners
      push_px(10, 5, 3); push_px(11, 5, 3); push_px(12, 5, 3);
      push_px(10, 6, 3); push_px(11, 6, 3); push_px(12, 6, 3);
      start_cmd(CMD_RECT, 12, 6, 10, 5, 3);
      wait_idle(bc);
      chk("rect_busy_cycles", bc, 6);
      chk("rect_q_empty", exp_q.size(), 0);

      // single-pixel RECT
      push_px(7, 7, 2);
      start_cmd(CMD_RECT, 7, 7, 7, 7, 2);
      wait_idle(bc);
      chk("rect1_busy_cycles", bc, 1);

      // LINE shallow, reverse, steep and vertical
      push_px(0, 0, 1); push_px(1, 0, 1); push_px(2, 1, 1); push_px(3, 1, 1);
      start_cmd(CMD_LINE, 0, 0, 3, 1, 1);
      wait_idle(bc);
      chk("line_a_busy", bc, 4);
      push_px(3, 1, 6); push_px(2, 1, 6); push_px(1, 0, 6); push_px(0, 0, 6);
      start_cmd(CMD_LINE, 3, 1, 0, 0, 6);
      wait_idle(bc);
      chk("line_b_busy", bc, 4);
      push_px(0, 0, 4); push_px(0, 1, 4); push_px(1, 2, 4); push_px(1, 3, 4);
      start_cmd(CMD_LINE, 0, 0, 1, 3, 4);
      wait_idle(bc);
      chk("line_c_busy", bc, 4);
      for (int y = 9; y >= 2; y--) push_px(5, y, 2);
      start_cmd(CMD_LINE, 5, 9, 5, 2, 2);
      // request while busy must be ignored
      @(posedge clk);
      #1;
      gpu_command = CMD_POINT; gpu_x0 = 8'd0; gpu_y0 = 8'd0;
      gpu_execute_request = 1'b1;
      @(posedge clk);
      #1;
      gpu_execute_request = 1'b0;
      wait_idle(bc);
      chk("line_d_q_empty", exp_q.size(), 0);

      // request held across the end of a POINT: middle inputs ignored
      push_px(1, 1, 1); push_px(3, 3, 1);
      @(posedge clk);
      #1;
      gpu_command = CMD_POINT; gpu_x0 = 8'd1; gpu_y0 = 8'd1; gpu_colour = 3'd1;
      gpu_execute_request = 1'b1;
      @(posedge clk);
      #1;
      gpu_x0 = 8'd2; gpu_y0 = 8'd2;
      @(posedge clk);
      #1;
      gpu_x0 = 8'd3; gpu_y0 = 8'd3;
      @(posedge clk);
      #1;
      gpu_execute_request = 1'b0;
      wait_idle(bc);
      chk("b2b_q_empty", exp_q.size(), 0);

      // RECT partially off-screen
      for (int y = 150; y <= 152; y++)
         for (int x = 200; x <= 212; x++) push_px(x, y, 5);
      start_cmd(CMD_RECT, 200, 150, 220, 152, 5);
      wait_idle(bc);
      chk("clip_busy_cycles", bc, 63);
      chk("clip_q_empty", exp_q.size(), 0);

      // FILL with alternating fb_ready
      for (int a = 0; a < 34080; a++) exp_q.push_back((a << 3) | 7);
      toggle_en = 1'b1;
      start_cmd(CMD_FILL, 0, 0, 0, 0, 7);
      wait_idle(bc);
      toggle_en = 1'b0;
      chk("fill_q_empty", exp_q.size(), 0);
      chk("fill_last_addr", last_addr, 34079);
      repeat (2) @(negedge clk);

      // reset in the middle of a FILL
      mon_free = 1'b1;
      start_cmd(CMD_FILL, 0, 0, 0, 0, 4);
      repeat (50) @(posedge clk);
      #3;
      rst_async = 1'b0;
      #1;
      chk("midrst_we", fb_we, 0);
      chk("midrst_busy", gpu_busy, 0);
      chk("midrst_perf", perf_pixels, 0);
      repeat (2) @(negedge clk);
      rst_async = 1'b1;
      repeat (2) @(negedge clk);
      chk("postrst_busy", gpu_busy, 0);
      exp_q.delete();
      mon_free = 1'b0;
      push_px(0, 0, 6);
      start_cmd(CMD_POINT, 0, 0, 0, 0, 6);
      wait_idle(bc);
      chk("postrst_point_busy", bc, 1);
      chk("postrst_q_empty", exp_q.size(), 0);
`ifdef RASTER_PERF_COUNT_EN
      chk("perf_after_point", perf_pixels, 1);
`else
      chk("perf_tied_zero", perf_pixels, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/raster_engine.md
Name: raster_engine

Overview:
- GPU raster stage directly downstream of the CPU command interface.
- Accepts one raster command (fill, point, line or filled rect) plus coordinates and colour.
- Walks the covered pixels one per cycle and emits framebuffer write requests with backpressure.
- Holds gpu_busy while drawing; the CPU must not issue a new command while busy is high.

Parameters:
- FB_WIDTH, 213, framebuffer width in pixels; x ≥ FB_WIDTH is off-screen.
- FB_HEIGHT, 160, framebuffer height in pixels; y ≥ FB_HEIGHT is off-screen.
- ADDR_W, 16, framebuffer address width; must satisfy FB_WIDTH*FB_HEIGHT ≤ 2^ADDR_W.

Ports:
- clk  in  1  system clock, 50 MHz
- rst_async  in  1  asynchronous active-low reset
- gpu_command  in  raster_command_t (2)  FILL=0, POINT=1, LINE=2, RECT=3 (common package)
- gpu_x0, gpu_y0, gpu_x1, gpu_y1  in  8 each  command coordinates
- gpu_colour  in  3  pixel colour
- gpu_execute_request  in  1  start pulse, sampled each cycle
- gpu_busy  out  1  command in progress
- fb_we  out  1  pixel write valid
- fb_addr  out  ADDR_W  y*FB_WIDTH + x
- fb_data  out  3  colour to write
- fb_ready  in  1  framebuffer accepts write when fb_we && fb_ready
- perf_pixels  out  32  accepted-write count (see Optional Feature)

Behaviour:
- Reset (rst_async low, any time including mid-command): state IDLE, gpu_busy=0, fb_we=0, fb_addr=0, fb_data=0, perf_pixels=0. Any command in progress is abandoned; no further writes.
- Accept: in IDLE, when gpu_execute_request=1 in cycle N, latch command, coordinates and colour.
  - gpu_busy=1 and first candidate pixel both appear in cycle N+1.
  - gpu_execute_request while busy is ignored; inputs are not re-sampled.
- States: IDLE, FILL, POINT, RECT, LINE. Each drawing state returns to IDLE after its last pixel is accepted.
- Pixel step: a candidate pixel advances only when fb_we && fb_ready, or when the pixel is clipped.
  - While fb_ready=0, fb_addr and fb_data hold stable.
- Clipping: a candidate with x ≥ FB_WIDTH or y ≥ FB_HEIGHT drives fb_we=0 and advances next cycle. It costs one cycle but makes no write.
- FILL: every pixel in row-major order, (0,0) to (FB_WIDTH-1, FB_HEIGHT-1). FB_WIDTH*FB_HEIGHT writes.
- POINT: single pixel (x0,y0).
- RECT: filled and inclusive; xl=min(x0,x1), xh=max(x0,x1), yl=min(y0,y1), yh=max(y0,y1).
  - Row-major from (xl,yl). x wraps from xh to xl and increments y.
  - Ends after (xh,yh). x0==x1 and y0==y1 yields exactly one pixel.
- LINE: Bresenham from (x0,y0) to (x1,y1) inclusive, any octant.
  - Pixel count = max(|dx|,|dy|)+1.
  - dx, dy are 9-bit signed; error term is 10-bit signed.
  - Endpoint (x1,y1) is always drawn exactly once.
- Done: gpu_busy drops in the cycle after the final pixel is accepted or clipped. A new request may be accepted in that same cycle.
- Address arithmetic is computed from the current x,y each step. No wrap-around occurs because coordinates are ≤ 255 and off-screen pixels are clipped.

Optional Feature:
- Macro RASTER_PERF_COUNT_EN.
  - Defined: perf_pixels increments by 1 on every cycle with fb_we && fb_ready. It wraps at 2^32 and is cleared only by reset.
  - Undefined: perf_pixels is tied to 0 and no counter logic exists.

Test Plan:
- POINT (10,20) colour 5, fb_ready=1 → cycle N+1: fb_we=1, fb_addr=4270, fb_data=5. Cycle N+2: gpu_busy=0.
- RECT x0=12,y0=6,x1=10,y1=5 colour 3 → 6 writes in order (10,5),(11,5),(12,5),(10,6),(11,6),(12,6); busy high exactly 6 cycles.
- LINE (0,0)→(3,1) → exactly 4 writes at (0,0),(1,0),(2,1),(3,1); LINE (5,9)→(5,2) → 8 writes, y descending 9..2, x=5.
- RECT (200,150)→(220,152) → 63 candidate cycles; only x 200..212 written (39 writes), none with x ≥ 213.
- FILL colour 7 with fb_ready toggled 1-0-1-0 → 34080 writes with no address repeats or skips; fb_addr/fb_data stable while fb_ready=0; final address 34079.
- rst_async low mid-FILL → fb_we and gpu_busy are 0 immediately; after release, a POINT (0,0) completes normally. With RASTER_PERF_COUNT_EN, perf_pixels=1.
